// File: rtl/motor_cmd_scheduler.sv
// Motor command scheduler: builds 3-byte UART frames into a command queue and plays them to the PWM pair.
// A frame acts 1 clk after its last byte and IDLE starts a queued command 1 clk later; a full queue drops frames.
module motor_cmd_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)
        count <= count + 1'b1;
      else if (pop_ok && !push_ok)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end
endmodule

module motor_cmd_scheduler #(
  parameter int FIFO_DEPTH   = 4,
  parameter int TICK_DIV     = 400000,
  parameter int BYTE_TIMEOUT = 40000,
  parameter int DEAD_CYCLES  = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_valid,
  output logic [6:0]                  lduty,
  output logic [6:0]                  rduty,
  output logic                        ldir,
  output logic                        rdir,
  output logic                        motor_en,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        frame_err
);
  typedef struct packed {
    logic       dir;
    logic [6:0] duty;
  } mot_t;

  typedef struct packed {
    mot_t       l;
    mot_t       r;
    logic [7:0] dur;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  localparam int TW = (TICK_DIV > 1)     ? $clog2(TICK_DIV)     : 1;
  localparam int DW = (DEAD_CYCLES > 1)  ? $clog2(DEAD_CYCLES)  : 1;
  localparam int OW = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;

  logic [1:0]    byte_idx;
  logic [7:0]    lbyte;
  logic [7:0]    rbyte;
  logic [OW-1:0] idle_cnt;
  logic          frame_vld;
  cmd_t          frame;
  logic          stop;
  logic          push_req;

  logic [23:0]   head_dat;
  cmd_t          head;
  logic          fifo_full;
  logic          fifo_empty;

  state_t        state;
  state_t        state_nxt;
  mot_t          cur_l;
  mot_t          cur_r;
  logic [7:0]    remaining;
  logic [TW-1:0] tick;
  logic [DW-1:0] dead_cnt;
  logic          pop;
  logic          tick_last;
  logic          cmd_end;
  logic          dir_change;
  logic          dead_done;

  // Byte assembly; a completed frame is registered and acted on one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx  <= 2'd0;
      lbyte     <= '0;
      rbyte     <= '0;
      idle_cnt  <= '0;
      frame_vld <= 1'b0;
      frame     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
      if (byte_valid) begin
        idle_cnt <= '0;
        case (byte_idx)
          2'd0: begin
            lbyte    <= byte_in;
            byte_idx <= 2'd1;
          end
          2'd1: begin
            rbyte    <= byte_in;
            byte_idx <= 2'd2;
          end
          default: begin
            frame     <= {lbyte, rbyte, byte_in};
            frame_vld <= 1'b1;
            byte_idx  <= 2'd0;
          end
        endcase
      end else if (byte_idx != 2'd0) begin
        if (idle_cnt == OW'(BYTE_TIMEOUT - 1)) begin
          byte_idx  <= 2'd0;
          idle_cnt  <= '0;
          frame_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

  assign stop     = frame_vld && (frame.dur == 8'd0);
  assign push_req = frame_vld && !stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overflow <= 1'b0;
    else if (stop)
      overflow <= 1'b0;
    else if (push_req && fifo_full)
      overflow <= 1'b1;
  end

  motor_cmd_fifo #(
    .WIDTH (24),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (stop),
    .push     (push_req),
    .push_dat (frame),
    .pop      (pop),
    .pop_dat  (head_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign head       = head_dat;
  assign tick_last  = (tick == TW'(TICK_DIV - 1));
  assign cmd_end    = (state == RUN) && tick_last && (remaining == 8'd1);
  assign dir_change = (head.l.dir != cur_l.dir) || (head.r.dir != cur_r.dir);
  assign dead_done  = (state == DEAD) && (dead_cnt == DW'(DEAD_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cmd_end) begin
          if (fifo_empty)
            state_nxt = IDLE;
          else if (dir_change)
            state_nxt = DEAD;
          else
            pop = 1'b1;
        end
      end
      DEAD: begin
        if (dead_done) begin
          pop       = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Stop frame overrides any pop this cycle.
    if (stop) begin
      state_nxt = IDLE;
      pop       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_l     <= '0;
      cur_r     <= '0;
      remaining <= '0;
      tick      <= '0;
      dead_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (stop) begin
        cur_l     <= '0;
        cur_r     <= '0;
        remaining <= '0;
        tick      <= '0;
        dead_cnt  <= '0;
      end else if (pop) begin
        cur_l     <= head.l;
        cur_r     <= head.r;
        remaining <= head.dur;
        tick      <= '0;
        dead_cnt  <= '0;
      end else if (state == RUN) begin
        dead_cnt <= '0;
        if (tick_last) begin
          tick      <= '0;
          remaining <= remaining - 1'b1;
        end else begin
          tick <= tick + 1'b1;
        end
      end else if (state == DEAD) begin
        dead_cnt <= dead_cnt + 1'b1;
      end
    end
  end

  assign motor_en = (state == RUN);
  assign busy     = (state != IDLE);
  assign lduty    = motor_en ? cur_l.duty : 7'd0;
  assign rduty    = motor_en ? cur_r.duty : 7'd0;
  assign ldir     = motor_en ? cur_l.dir  : 1'b0;
  assign rdir     = motor_en ? cur_r.dir  : 1'b0;
endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Directed bench for motor_cmd_scheduler: TICK_DIV=4, DEAD_CYCLES=3, BYTE_TIMEOUT=10, FIFO_DEPTH=4.
module tb_motor_cmd_scheduler;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic [6:0] lduty;
  logic [6:0] rduty;
  logic       ldir;
  logic       rdir;
  logic       motor_en;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       frame_err;
  int         total = 0;
  int         bad = 0;

  motor_cmd_scheduler #(
    .FIFO_DEPTH   (4),
    .TICK_DIV     (4),
    .BYTE_TIMEOUT (10),
    .DEAD_CYCLES  (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .lduty      (lduty),
    .rduty      (rduty),
    .ldir       (ldir),
    .rdir       (rdir),
    .motor_en   (motor_en),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Three back-to-back bytes; returns on the negedge after the last byte's sampling edge.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    @(negedge clk); byte_in = a; byte_valid = 1'b1;
    @(negedge clk); byte_in = b;
    @(negedge clk); byte_in = c;
    @(negedge clk); byte_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #2;
    total++;
    if ({motor_en, busy, ldir, rdir, lduty, rduty, fifo_count, overflow, frame_err} !== 23'd0) begin
      bad++;
      $display("FAIL reset_hold: got en=%b busy=%b l=%0d r=%0d cnt=%0d ovf=%b ferr=%b, want all 0",
               motor_en, busy, lduty, rduty, fifo_count, overflow, frame_err);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({motor_en, busy, ldir, rdir, lduty, rduty, fifo_count, overflow, frame_err} !== 23'd0) begin
      bad++;
      $display("FAIL reset_release: got en=%b busy=%b l=%0d r=%0d cnt=%0d, want all 0",
               motor_en, busy, lduty, rduty, fifo_count);
    end
  endtask

  task automatic test_single_cmd;
    send_frame(8'h40, 8'h20, 8'h02);
    @(negedge clk);
    total++;
    if ({busy, fifo_count} !== {1'b0, 3'd1}) begin
      bad++;
      $display("FAIL single_queued: got busy=%b cnt=%0d, want busy=0 cnt=1", busy, fifo_count);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if ({motor_en, busy, ldir, rdir, lduty, rduty, fifo_count} !==
          {1'b1, 1'b1, 1'b0, 1'b0, 7'd64, 7'd32, 3'd0}) begin
        bad++;
        $display("FAIL single_run cyc=%0d: got en=%b busy=%b dirs=%b%b l=%0d r=%0d cnt=%0d, want en=1 busy=1 dirs=00 l=64 r=32 cnt=0",
                 i, motor_en, busy, ldir, rdir, lduty, rduty, fifo_count);
      end
    end
    @(negedge clk);
    total++;
    if ({motor_en, busy, ldir, rdir, lduty, rduty, fifo_count} !== 20'd0) begin
      bad++;
      $display("FAIL single_idle: got en=%b busy=%b l=%0d r=%0d, want all 0", motor_en, busy, lduty, rduty);
    end
  endtask

  task automatic test_dead_time;
    logic       en_t [18];
    logic       ld_t [18];
    logic [6:0] l_t  [18];
    logic       exp_en;
    logic       exp_ld;
    fork
      begin
        send_frame(8'h10, 8'h10, 8'h01);
        send_frame(8'h90, 8'h10, 8'h01);
      end
      for (int i = 0; i < 18; i++) begin
        @(negedge clk);
        en_t[i] = motor_en;
        ld_t[i] = ldir;
        l_t[i]  = lduty;
      end
    join
    for (int i = 0; i < 18; i++) begin
      exp_en = ((i >= 5) && (i <= 8)) || ((i >= 12) && (i <= 15));
      exp_ld = (i >= 12) && (i <= 15);
      total++;
      if ({en_t[i], l_t[i]} !== {exp_en, exp_en ? 7'd16 : 7'd0} || (exp_en && (ld_t[i] !== exp_ld))) begin
        bad++;
        $display("FAIL dead_time cyc=%0d: got en=%b ldir=%b l=%0d, want en=%b ldir=%b l=%0d",
                 i, en_t[i], ld_t[i], l_t[i], exp_en, exp_ld, exp_en ? 16 : 0);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic       en_t [15];
    logic [6:0] l_t  [15];
    logic [6:0] r_t  [15];
    logic       exp_en;
    logic [6:0] exp_d;
    fork
      begin
        send_frame(8'h05, 8'h05, 8'h01);
        send_frame(8'h07, 8'h07, 8'h01);
      end
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        en_t[i] = motor_en;
        l_t[i]  = lduty;
        r_t[i]  = rduty;
      end
    join
    for (int i = 0; i < 15; i++) begin
      exp_en = (i >= 5) && (i <= 12);
      exp_d  = !exp_en ? 7'd0 : ((i <= 8) ? 7'd5 : 7'd7);
      total++;
      if ({en_t[i], l_t[i], r_t[i]} !== {exp_en, exp_d, exp_d}) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d: got en=%b l=%0d r=%0d, want en=%b l=%0d r=%0d",
                 i, en_t[i], l_t[i], r_t[i], exp_en, exp_d, exp_d);
      end
    end
  endtask

  task automatic test_overflow;
    send_frame(8'h01, 8'h01, 8'h0A);
    for (int k = 0; k < 4; k++) send_frame(8'h02, 8'h02, 8'h01);
    @(negedge clk);
    total++;
    if ({fifo_count, overflow, motor_en, lduty} !== {3'd4, 1'b0, 1'b1, 7'd1}) begin
      bad++;
      $display("FAIL overflow_full: got cnt=%0d ovf=%b en=%b l=%0d, want cnt=4 ovf=0 en=1 l=1",
               fifo_count, overflow, motor_en, lduty);
    end
    send_frame(8'h03, 8'h03, 8'h01);
    @(negedge clk);
    total++;
    if ({fifo_count, overflow, motor_en, lduty} !== {3'd4, 1'b1, 1'b1, 7'd1}) begin
      bad++;
      $display("FAIL overflow_drop: got cnt=%0d ovf=%b en=%b l=%0d, want cnt=4 ovf=1 en=1 l=1",
               fifo_count, overflow, motor_en, lduty);
    end
  endtask

  task automatic test_stop;
    send_frame(8'h00, 8'h00, 8'h00);
    total++;
    if ({busy, fifo_count, overflow} !== {1'b1, 3'd4, 1'b1}) begin
      bad++;
      $display("FAIL stop_pending: got busy=%b cnt=%0d ovf=%b, want busy=1 cnt=4 ovf=1", busy, fifo_count, overflow);
    end
    @(negedge clk);
    total++;
    if ({motor_en, busy, ldir, rdir, lduty, rduty, fifo_count, overflow} !== 22'd0) begin
      bad++;
      $display("FAIL stop_apply: got en=%b busy=%b l=%0d r=%0d cnt=%0d ovf=%b, want all 0",
               motor_en, busy, lduty, rduty, fifo_count, overflow);
    end
    repeat (6) @(negedge clk);
    total++;
    if ({busy, motor_en, fifo_count} !== 5'd0) begin
      bad++;
      $display("FAIL stop_stays_idle: got busy=%b en=%b cnt=%0d, want 0 0 0", busy, motor_en, fifo_count);
    end
  endtask

  task automatic test_timeout;
    @(negedge clk); byte_in = 8'h40; byte_valid = 1'b1;
    @(negedge clk); byte_valid = 1'b0;
    for (int i = 2; i <= 14; i++) begin
      @(negedge clk);
      total++;
      if (frame_err !== (i == 11)) begin
        bad++;
        $display("FAIL timeout_pulse cyc=%0d: got frame_err=%b, want %b", i, frame_err, (i == 11));
      end
    end
    send_frame(8'h20, 8'h10, 8'h03);
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({motor_en, lduty, rduty} !== {1'b1, 7'd32, 7'd16}) begin
      bad++;
      $display("FAIL timeout_realign: got en=%b l=%0d r=%0d, want en=1 l=32 r=16", motor_en, lduty, rduty);
    end
  endtask

  task automatic test_reset_mid_run;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({motor_en, busy, ldir, rdir, lduty, rduty, fifo_count, overflow} !== 22'd0) begin
      bad++;
      $display("FAIL reset_mid_run: got en=%b busy=%b l=%0d r=%0d cnt=%0d, want all 0",
               motor_en, busy, lduty, rduty, fifo_count);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if ({motor_en, busy, lduty, fifo_count} !== 12'd0) begin
      bad++;
      $display("FAIL reset_no_survivor: got en=%b busy=%b l=%0d cnt=%0d, want all 0",
               motor_en, busy, lduty, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_cmd();
    test_dead_time();
    test_back_to_back();
    test_overflow();
    test_stop();
    test_timeout();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
